// File: rtl/frt_irq_ctrl.sv
// frt_irq_ctrl -- interrupt scheduler for the free-running timer.
//
// Holds the FRT priority level (IPRB[11:8]) and the FRT vector numbers
// (VCRC, VCRD) as IBUS registers. It arbitrates the ICI/OCI/OVI requests in
// fixed order and runs the request/acknowledge handshake with the CPU,
// followed by a guard window before a new request may be raised.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   CE_R, CE_F          rising-phase enable (state, writes), falling-phase
//                       enable (read data register)
//   RES_N               soft reset, active-low, sampled on CE_R
//   ICI/OCIA/OCIB/OVI_IRQ  FRT request levels
//   IBUS_*              32-bit big-endian register bus
//   INT_REQ/LVL/VEC     request to the CPU interrupt interface
//   INT_ACK             CPU acknowledge, one CE_R cycle wide
module frt_irq_ctrl #(
  parameter int GUARD_CYC = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        RES_N,
  input  logic        ICI_IRQ,
  input  logic        OCIA_IRQ,
  input  logic        OCIB_IRQ,
  input  logic        OVI_IRQ,
  input  logic [31:0] IBUS_A,
  input  logic [31:0] IBUS_DI,
  output logic [31:0] IBUS_DO,
  input  logic [3:0]  IBUS_BA,
  input  logic        IBUS_WE,
  input  logic        IBUS_REQ,
  output logic        IBUS_BUSY,
  output logic        IBUS_ACT,
  output logic        INT_REQ,
  output logic [3:0]  INT_LVL,
  output logic [7:0]  INT_VEC,
  input  logic        INT_ACK
);

  localparam logic [31:0] ADDR_IPRB  = 32'hFFFF_FE60;
  localparam logic [31:0] ADDR_VCRC  = 32'hFFFF_FE66;
  localparam logic [31:0] ADDR_VCRD  = 32'hFFFF_FE68;
  localparam logic [3:0]  GUARD_LOAD = 4'(GUARD_CYC - 1);

  typedef enum logic [1:0] {IDLE, REQ, ACK, GUARD} state_t;
  typedef enum logic [1:0] {SRC_ICI, SRC_OCI, SRC_OVI} src_t;

  // Registers
  logic [3:0]  flvl;
  logic [6:0]  ficv, focv, fovv;
  logic [15:0] rd_hw;

  // Bus decode
  logic [31:0] a_hw;
  logic [15:0] hw_di, hw_rd;
  logic        be_hi, be_lo;
  logic        unused_di;

  assign IBUS_BUSY = 1'b0;
  assign IBUS_ACT  = (IBUS_A[31:4] == 28'hFFFF_FE6) && (IBUS_A[3:0] <= 4'h9);
  assign a_hw      = {IBUS_A[31:1], 1'b0};

  // Halfword at A[1]=0 lives on the upper lanes, A[1]=1 on the lower lanes.
  assign hw_di     = IBUS_A[1] ? IBUS_DI[15:0] : IBUS_DI[31:16];
  assign be_hi     = IBUS_A[1] ? IBUS_BA[1] : IBUS_BA[3];
  assign be_lo     = IBUS_A[1] ? IBUS_BA[0] : IBUS_BA[2];
  assign unused_di = hw_di[15] ^ hw_di[7];

  always_comb begin
    hw_rd = '0;
    case (a_hw)
      ADDR_IPRB: hw_rd = {4'h0, flvl, 8'h00};
      ADDR_VCRC: hw_rd = {1'b0, ficv, 1'b0, focv};
      ADDR_VCRD: hw_rd = {1'b0, fovv, 8'h00};
      default:   hw_rd = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flvl <= '0;
      ficv <= '0;
      focv <= '0;
      fovv <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        flvl <= '0;
        ficv <= '0;
        focv <= '0;
        fovv <= '0;
      end else if (IBUS_REQ && IBUS_WE) begin
        case (a_hw)
          ADDR_IPRB: if (be_hi) flvl <= hw_di[11:8];
          ADDR_VCRC: begin
            if (be_hi) ficv <= hw_di[14:8];
            if (be_lo) focv <= hw_di[6:0];
          end
          ADDR_VCRD: if (be_hi) fovv <= hw_di[14:8];
          default: ;
        endcase
      end
    end
  end

  // Read register survives soft reset; only RST clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_hw <= '0;
    end else if (CE_F && IBUS_REQ && !IBUS_WE && IBUS_ACT) begin
      rd_hw <= hw_rd;
    end
  end

  assign IBUS_DO = IBUS_ACT ? {rd_hw, rd_hw} : '0;

  // Arbitration: ICI > OCI > OVI
  logic       oci, valid;
  src_t       cand_src;
  logic [7:0] cand_vec;

  assign oci = OCIA_IRQ | OCIB_IRQ;

  always_comb begin
    cand_src = SRC_ICI;
    cand_vec = {1'b0, ficv};
    if (ICI_IRQ) begin
      cand_src = SRC_ICI;
      cand_vec = {1'b0, ficv};
    end else if (oci) begin
      cand_src = SRC_OCI;
      cand_vec = {1'b0, focv};
    end else begin
      cand_src = SRC_OVI;
      cand_vec = {1'b0, fovv};
    end
    valid = (ICI_IRQ | oci | OVI_IRQ) && (flvl != 4'h0);
  end

  // Handshake FSM; request outputs are registered alongside the state.
  state_t     state, state_nxt;
  src_t       src, src_nxt;
  logic       req_nxt;
  logic [3:0] lvl_nxt, guard_cnt, guard_nxt;
  logic [7:0] vec_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      src       <= SRC_ICI;
      guard_cnt <= '0;
      INT_REQ   <= 1'b0;
      INT_LVL   <= '0;
      INT_VEC   <= '0;
    end else if (CE_R) begin
      if (!RES_N) begin
        state     <= IDLE;
        src       <= SRC_ICI;
        guard_cnt <= '0;
        INT_REQ   <= 1'b0;
        INT_LVL   <= '0;
        INT_VEC   <= '0;
      end else begin
        state     <= state_nxt;
        src       <= src_nxt;
        guard_cnt <= guard_nxt;
        INT_REQ   <= req_nxt;
        INT_LVL   <= lvl_nxt;
        INT_VEC   <= vec_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    src_nxt   = src;
    guard_nxt = guard_cnt;
    req_nxt   = INT_REQ;
    lvl_nxt   = INT_LVL;
    vec_nxt   = INT_VEC;
    case (state)
      IDLE: begin
        req_nxt = 1'b0;
        if (valid) begin
          state_nxt = REQ;
          src_nxt   = cand_src;
          vec_nxt   = cand_vec;
          lvl_nxt   = flvl;
          req_nxt   = 1'b1;
        end
      end
      REQ: begin
        // Acknowledge beats withdrawal and freezes the presented level/vector.
        if (INT_ACK) begin
          state_nxt = ACK;
          req_nxt   = 1'b0;
        end else if (!valid) begin
          state_nxt = IDLE;
          req_nxt   = 1'b0;
          lvl_nxt   = flvl;
        end else begin
          lvl_nxt = flvl;
          if (cand_src != src) begin
            src_nxt = cand_src;
            vec_nxt = cand_vec;
          end
        end
      end
      ACK: begin
        req_nxt   = 1'b0;
        guard_nxt = GUARD_LOAD;
        state_nxt = GUARD;
      end
      GUARD: begin
        req_nxt = 1'b0;
        if (guard_cnt == 4'h0) state_nxt = IDLE;
        else                   guard_nxt = guard_cnt - 4'h1;
      end
      default: begin
        state_nxt = IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_frt_irq_ctrl.sv
// Directed bench for frt_irq_ctrl (GUARD_CYC=3, CE_R/CE_F held high).
module tb_frt_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_r = 1'b1, ce_f = 1'b1, res_n = 1'b1;
  logic        ici = 1'b0, ocia = 1'b0, ocib = 1'b0, ovi = 1'b0;
  logic [31:0] ibus_a = '0, ibus_di = '0;
  logic [31:0] ibus_do;
  logic [3:0]  ibus_ba = '0;
  logic        ibus_we = 1'b0, ibus_req = 1'b0;
  logic        ibus_busy, ibus_act;
  logic        int_req;
  logic [3:0]  int_lvl;
  logic [7:0]  int_vec;
  logic        int_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  frt_irq_ctrl #(.GUARD_CYC(3)) dut (
    .CLK(clk), .RST(rst), .CE_R(ce_r), .CE_F(ce_f), .RES_N(res_n),
    .ICI_IRQ(ici), .OCIA_IRQ(ocia), .OCIB_IRQ(ocib), .OVI_IRQ(ovi),
    .IBUS_A(ibus_a), .IBUS_DI(ibus_di), .IBUS_DO(ibus_do), .IBUS_BA(ibus_ba),
    .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req), .IBUS_BUSY(ibus_busy),
    .IBUS_ACT(ibus_act), .INT_REQ(int_req), .INT_LVL(int_lvl),
    .INT_VEC(int_vec), .INT_ACK(int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ba);
    ibus_a = a; ibus_di = d; ibus_ba = ba; ibus_we = 1'b1; ibus_req = 1'b1;
    tick();
    ibus_we = 1'b0; ibus_req = 1'b0; ibus_ba = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a);
    ibus_a = a; ibus_we = 1'b0; ibus_req = 1'b1;
    tick();
    ibus_req = 1'b0;
  endtask

  initial begin
    // Reset state
    ibus_a = 32'hFFFF_FE60;
    tick(); tick();
    check("rst_req", {31'b0, int_req}, 32'h0);
    check("rst_lvl", {28'b0, int_lvl}, 32'h0);
    check("rst_vec", {24'b0, int_vec}, 32'h0);
    check("rst_do", ibus_do, 32'h0);
    rst = 1'b0;
    tick();

    // Program FLVL=A, FICV=40, FOCV=41, FOVV=43
    bus_wr(32'hFFFF_FE60, 32'h0A00_0000, 4'b1000);
    bus_wr(32'hFFFF_FE66, 32'h0000_4041, 4'b0011);
    bus_wr(32'hFFFF_FE68, 32'h4300_0000, 4'b1100);
    bus_rd(32'hFFFF_FE66);
    check("rd_vcrc", ibus_do, 32'h4041_4041);

    // ICI request, one-cycle latency, then withdrawal
    ici = 1'b1;
    #1;
    check("ici_pre", {31'b0, int_req}, 32'h0);
    tick();
    check("ici_req", {31'b0, int_req}, 32'h1);
    check("ici_lvl", {28'b0, int_lvl}, 32'hA);
    check("ici_vec", {24'b0, int_vec}, 32'h40);
    ici = 1'b0;
    tick();
    check("withdraw_req", {31'b0, int_req}, 32'h0);

    // OVI, then ICI preempts, then acknowledge
    ovi = 1'b1;
    tick();
    check("ovi_req", {31'b0, int_req}, 32'h1);
    check("ovi_vec", {24'b0, int_vec}, 32'h43);
    ici = 1'b1;
    tick();
    check("preempt_req", {31'b0, int_req}, 32'h1);
    check("preempt_vec", {24'b0, int_vec}, 32'h40);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("ack_req", {31'b0, int_req}, 32'h0);
    check("ack_vec", {24'b0, int_vec}, 32'h40);
    // ACK state, three GUARD cycles, then IDLE re-requests
    for (int i = 0; i < 4; i++) begin
      tick();
      check("guard_req", {31'b0, int_req}, 32'h0);
      check("guard_vec", {24'b0, int_vec}, 32'h40);
    end
    tick();
    check("rereq_req", {31'b0, int_req}, 32'h1);
    check("rereq_vec", {24'b0, int_vec}, 32'h40);

    // FLVL written to 0 while in REQ withdraws on the following edge
    bus_wr(32'hFFFF_FE60, 32'h0000_0000, 4'b1000);
    check("flvl0_hold", {31'b0, int_req}, 32'h1);
    tick();
    check("flvl0_wd", {31'b0, int_req}, 32'h0);
    ici = 1'b0; ovi = 1'b0;
    bus_wr(32'hFFFF_FE60, 32'h0A00_0000, 4'b1000);

    // INT_ACK in IDLE has no effect: next request is immediate
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    check("idle_ack_req", {31'b0, int_req}, 32'h0);
    ici = 1'b1;
    tick();
    check("idle_ack_rereq", {31'b0, int_req}, 32'h1);
    check("idle_ack_vec", {24'b0, int_vec}, 32'h40);

    // Acknowledge together with a vector write: presented vector frozen
    int_ack = 1'b1;
    ibus_a = 32'hFFFF_FE66; ibus_di = 32'h0000_5041; ibus_ba = 4'b0011;
    ibus_we = 1'b1; ibus_req = 1'b1;
    tick();
    int_ack = 1'b0; ibus_we = 1'b0; ibus_req = 1'b0; ibus_ba = '0;
    check("ackwr_req", {31'b0, int_req}, 32'h0);
    check("ackwr_vec", {24'b0, int_vec}, 32'h40);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ackwr_guard", {31'b0, int_req}, 32'h0);
    end
    tick();
    check("ackwr_newreq", {31'b0, int_req}, 32'h1);
    check("ackwr_newvec", {24'b0, int_vec}, 32'h50);

    // Acknowledge with simultaneous withdrawal: acknowledge wins (guard runs)
    ici = 1'b0; int_ack = 1'b1;
    tick();
    int_ack = 1'b0; ici = 1'b1;
    check("ackwd_req0", {31'b0, int_req}, 32'h0);
    tick();
    check("ackwd_guard", {31'b0, int_req}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ackwd_guard2", {31'b0, int_req}, 32'h0);
    end
    tick();
    check("ackwd_rereq", {31'b0, int_req}, 32'h1);
    check("ackwd_vec", {24'b0, int_vec}, 32'h50);

    // OCIA and OCIB together: single OCI request with FOCV
    ici = 1'b0; ocia = 1'b1; ocib = 1'b1;
    tick();
    check("oci_req", {31'b0, int_req}, 32'h1);
    check("oci_vec", {24'b0, int_vec}, 32'h41);

    // Bus lane tests
    bus_wr(32'hFFFF_FE66, 32'h0000_0512, 4'b0011);
    bus_rd(32'hFFFF_FE66);
    check("rd_0512", ibus_do, 32'h0512_0512);
    check("oci_vec_kept", {24'b0, int_vec}, 32'h41);
    bus_wr(32'hFFFF_FE60, 32'hF7FF_FFFF, 4'b1000);
    bus_rd(32'hFFFF_FE60);
    check("rd_iprb_ba3", ibus_do, 32'h0700_0700);
    check("lvl_track", {28'b0, int_lvl}, 32'h7);
    bus_wr(32'hFFFF_FE60, 32'hFFFF_FFFF, 4'b0100);
    bus_rd(32'hFFFF_FE60);
    check("rd_iprb_ba2", ibus_do, 32'h0700_0700);

    // Address window and constant busy
    ibus_a = 32'hFFFF_FE69; #1;
    check("act_69", {31'b0, ibus_act}, 32'h1);
    ibus_a = 32'hFFFF_FE6A; #1;
    check("act_6a", {31'b0, ibus_act}, 32'h0);
    check("do_unsel", ibus_do, 32'h0);
    ibus_a = 32'hFFFF_FE5F; #1;
    check("act_5f", {31'b0, ibus_act}, 32'h0);
    check("busy", {31'b0, ibus_busy}, 32'h0);

    // Asynchronous reset mid-REQ
    ibus_a = 32'hFFFF_FE60;
    rst = 1'b1;
    #1;
    check("arst_req", {31'b0, int_req}, 32'h0);
    check("arst_lvl", {28'b0, int_lvl}, 32'h0);
    check("arst_vec", {24'b0, int_vec}, 32'h0);
    check("arst_do", ibus_do, 32'h0);
    tick();
    rst = 1'b0;

    // Soft reset
    ocia = 1'b0; ocib = 1'b0; ovi = 1'b1;
    bus_wr(32'hFFFF_FE68, 32'h4300_0000, 4'b1100);
    bus_wr(32'hFFFF_FE60, 32'h0A00_0000, 4'b1000);
    bus_rd(32'hFFFF_FE68);
    check("rd_vcrd", ibus_do, 32'h4300_4300);
    check("ovi2_req", {31'b0, int_req}, 32'h1);
    check("ovi2_vec", {24'b0, int_vec}, 32'h43);
    res_n = 1'b0;
    tick();
    res_n = 1'b1;
    check("sres_req", {31'b0, int_req}, 32'h0);
    check("sres_lvl", {28'b0, int_lvl}, 32'h0);
    check("sres_vec", {24'b0, int_vec}, 32'h0);
    bus_rd(32'hFFFF_FE68);
    check("sres_rd_vcrd", ibus_do, 32'h0);
    check("sres_noreq", {31'b0, int_req}, 32'h0);
    bus_rd(32'hFFFF_FE66);
    check("sres_rd_vcrc", ibus_do, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
